// File: rtl/vga_framebuffer_reader.sv
// vga_framebuffer_reader
//   Scan-out side of the 3-bit pixel framebuffer. Generates VGA timing,
//   reads the framebuffer in row-major order (addr = y*H_ACTIVE + x) and
//   drives sync, blank and 8-bit RGB to the DAC on the pixel clock.
//
// Ports
//   clock        pixel clock
//   reset        synchronous, active-high reset
//   mem_raddr    framebuffer read address for the current counter position
//   mem_rdata    framebuffer read data, valid RD_LATENCY clocks after address
//   vga_hsync    horizontal sync, active low
//   vga_vsync    vertical sync, active low
//   vga_blank_n  high during visible pixels
//   vga_r/g/b    8-bit colour, full scale per set framebuffer bit
//   frame_start  one-clock pulse aligned with the output of pixel (0,0)
module vga_framebuffer_reader #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int RD_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [18:0] mem_raddr,
    input  logic [2:0]  mem_rdata,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    logic [HW-1:0] h_count, h_next;
    logic [VW-1:0] v_count, v_next;
    logic [18:0]   addr;
    logic          active, active_next, hsync_raw, vsync_raw, origin;
    logic          h_last, v_last;

    // Delay lines; index RD_LATENCY-1 is the stage aligned with mem_rdata.
    logic [RD_LATENCY-1:0] act_pipe, hs_pipe, vs_pipe, fs_pipe;

    always_comb begin
        h_last = (int'(h_count) == H_TOTAL - 1);
        v_last = (int'(v_count) == V_TOTAL - 1);
        h_next = h_count + 1'b1;
        v_next = v_count;
        if (h_last) begin
            h_next = '0;
            v_next = v_last ? '0 : v_count + 1'b1;
        end
        active      = (int'(h_count) < H_ACTIVE) && (int'(v_count) < V_ACTIVE);
        active_next = (int'(h_next) < H_ACTIVE) && (int'(v_next) < V_ACTIVE);
        hsync_raw   = !((int'(h_count) >= HS_START) && (int'(h_count) < HS_END));
        vsync_raw   = !((int'(v_count) >= VS_START) && (int'(v_count) < VS_END));
        origin      = (h_count == '0) && (v_count == '0);
    end

    // Counters and linear read address. The address advances on entry to
    // each visible position except the frame origin, so it holds the last
    // visible address through blanking and never passes H_ACTIVE*V_ACTIVE-1.
    always_ff @(posedge clock) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
            addr    <= '0;
        end else begin
            h_count <= h_next;
            v_count <= v_next;
            if (h_last && v_last)
                addr <= '0;
            else if (active_next)
                addr <= addr + 19'd1;
        end
    end

    // Timing flags delayed to line up with the returning read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            act_pipe <= '0;
            hs_pipe  <= '1;
            vs_pipe  <= '1;
            fs_pipe  <= '0;
        end else begin
            act_pipe[0] <= active;
            hs_pipe[0]  <= hsync_raw;
            vs_pipe[0]  <= vsync_raw;
            fs_pipe[0]  <= origin;
            for (int i = 1; i < RD_LATENCY; i++) begin
                act_pipe[i] <= act_pipe[i-1];
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
                fs_pipe[i]  <= fs_pipe[i-1];
            end
        end
    end

    assign mem_raddr   = addr;
    assign vga_blank_n = act_pipe[RD_LATENCY-1];
    assign vga_hsync   = hs_pipe[RD_LATENCY-1];
    assign vga_vsync   = vs_pipe[RD_LATENCY-1];
    assign frame_start = fs_pipe[RD_LATENCY-1];

    // Read data is used in the cycle it arrives; blanking forces black.
    assign vga_r = {8{vga_blank_n & mem_rdata[2]}};
    assign vga_g = {8{vga_blank_n & mem_rdata[1]}};
    assign vga_b = {8{vga_blank_n & mem_rdata[0]}};

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Bench for vga_framebuffer_reader. Instance A uses default 640x480 timing
// for line-level checks; instance B uses a miniature 8x6 timing
// (16x10 total) so whole-frame behaviour fits in a short run.
module tb_vga_framebuffer_reader;

    logic        clock = 1'b0;
    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic        force_a = 1'b0;
    logic [18:0] raddr_a, raddr_b;
    logic [2:0]  rdata_a, rdata_b;
    logic        hs_a, vs_a, bn_a, fs_a, hs_b, vs_b, bn_b, fs_b;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    always #5 clock = ~clock;

    vga_framebuffer_reader dut_a (
        .clock(clock), .reset(rst_a), .mem_raddr(raddr_a), .mem_rdata(rdata_a),
        .vga_hsync(hs_a), .vga_vsync(vs_a), .vga_blank_n(bn_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .frame_start(fs_a));

    vga_framebuffer_reader #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .RD_LATENCY(2)
    ) dut_b (
        .clock(clock), .reset(rst_b), .mem_raddr(raddr_b), .mem_rdata(rdata_b),
        .vga_hsync(hs_b), .vga_vsync(vs_b), .vga_blank_n(bn_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .frame_start(fs_b));

    // Memory models: data = low address bits, two clocks after the address.
    logic [18:0] a1_a = '0, a2_a = '0, a1_b = '0, a2_b = '0;
    always @(posedge clock) begin
        a1_a <= raddr_a; a2_a <= a1_a;
        a1_b <= raddr_b; a2_b <= a1_b;
    end
    assign rdata_a = force_a ? 3'b111 : a2_a[2:0];
    assign rdata_b = a2_b[2:0];

    int errors = 0;
    int checks = 0;
    int kc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Cycle 0 is the first clock with reset low.
    task automatic release_a();
        @(posedge clock); #1 rst_a = 1'b0; kc = 0;
    endtask
    task automatic release_b();
        @(posedge clock); #1 rst_b = 1'b0; kc = 0;
    endtask
    // Advance to cycle k (strictly increasing) and stop at its falling edge.
    task automatic goto(input int k);
        if (k > kc) repeat (k - kc) @(posedge clock);
        kc = k;
        @(negedge clock);
    endtask

    typedef struct {
        int          k;
        logic [18:0] addr;
        logic        hs, vs, bn, fs;
        logic [23:0] rgb;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    initial begin
        int lo_bn, lo_hs, lo_vs, n_fs, bad, mx, first_hs, first_vs, exp_addr;
        bit saw_on, saw_off;

        //           k     addr  hs vs bn fs rgb
        vecs[0]  = '{0,    0,    1, 1, 0, 0, 24'h000000};
        vecs[1]  = '{1,    1,    1, 1, 0, 0, 24'h000000};
        vecs[2]  = '{2,    2,    1, 1, 1, 1, 24'h000000};
        vecs[3]  = '{3,    3,    1, 1, 1, 0, 24'h0000FF};
        vecs[4]  = '{4,    4,    1, 1, 1, 0, 24'h00FF00};
        vecs[5]  = '{9,    9,    1, 1, 1, 0, 24'hFFFFFF};
        vecs[6]  = '{639,  639,  1, 1, 1, 0, 24'hFF00FF};
        vecs[7]  = '{640,  639,  1, 1, 1, 0, 24'hFFFF00};
        vecs[8]  = '{641,  639,  1, 1, 1, 0, 24'hFFFFFF};
        vecs[9]  = '{642,  639,  1, 1, 0, 0, 24'h000000};
        vecs[10] = '{657,  639,  1, 1, 0, 0, 24'h000000};
        vecs[11] = '{658,  639,  0, 1, 0, 0, 24'h000000};
        vecs[12] = '{753,  639,  0, 1, 0, 0, 24'h000000};
        vecs[13] = '{754,  639,  1, 1, 0, 0, 24'h000000};
        vecs[14] = '{799,  639,  1, 1, 0, 0, 24'h000000};
        vecs[15] = '{800,  640,  1, 1, 0, 0, 24'h000000};
        vecs[16] = '{801,  641,  1, 1, 0, 0, 24'h000000};
        vecs[17] = '{802,  642,  1, 1, 1, 0, 24'h000000};
        vecs[18] = '{803,  643,  1, 1, 1, 0, 24'h0000FF};
        vecs[19] = '{1457, 1279, 1, 1, 0, 0, 24'h000000};
        vecs[20] = '{1458, 1279, 0, 1, 0, 0, 24'h000000};

        // ---------------- instance A: reset state ----------------
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("a_reset_outputs", {raddr_a, hs_a, vs_a, bn_a, fs_a, r_a, g_a, b_a},
            {19'd0, 4'b1100, 24'h0});
        chk("b_reset_outputs", {raddr_b, hs_b, vs_b, bn_b, fs_b, r_b, g_b, b_b},
            {19'd0, 4'b1100, 24'h0});

        // ---------------- instance A: vector table ----------------
        release_a();
        for (int i = 0; i < NV; i++) begin
            goto(vecs[i].k);
            chk($sformatf("a_addr@%0d", vecs[i].k), raddr_a, vecs[i].addr);
            chk($sformatf("a_hsync@%0d", vecs[i].k), hs_a, vecs[i].hs);
            chk($sformatf("a_vsync@%0d", vecs[i].k), vs_a, vecs[i].vs);
            chk($sformatf("a_blank_n@%0d", vecs[i].k), bn_a, vecs[i].bn);
            chk($sformatf("a_frame_start@%0d", vecs[i].k), fs_a, vecs[i].fs);
            chk($sformatf("a_rgb@%0d", vecs[i].k), {r_a, g_a, b_a}, vecs[i].rgb);
        end

        // One full output line (line 2): blank and hsync widths.
        lo_bn = 0; lo_hs = 0;
        for (int k = 1602; k < 2402; k++) begin
            goto(k);
            if (!bn_a) lo_bn++;
            if (!hs_a) lo_hs++;
        end
        chk("a_blank_low_per_line", lo_bn, 160);
        chk("a_hsync_low_per_line", lo_hs, 96);

        // Blanking override with memory stuck at 3'b111.
        force_a = 1'b1;
        bad = 0; saw_on = 0; saw_off = 0;
        for (int k = 2402; k < 4102; k++) begin
            goto(k);
            if (bn_a) begin
                saw_on = 1;
                if ({r_a, g_a, b_a} !== 24'hFFFFFF) bad++;
            end else begin
                saw_off = 1;
                if ({r_a, g_a, b_a} !== 24'h000000) bad++;
            end
        end
        chk("a_override_violations", bad, 0);
        chk("a_override_both_states", {saw_on, saw_off}, 2'b11);

        // ---------------- instance B: whole frame ----------------
        release_b();
        lo_bn = 0; lo_hs = 0; lo_vs = 0; n_fs = 0; bad = 0; mx = 0;
        for (int k = 0; k < 162; k++) begin
            goto(k);
            if (k >= 2) begin
                if (!bn_b) lo_bn++;
                if (!hs_b) lo_hs++;
                if (!vs_b) lo_vs++;
                if (fs_b) n_fs++;
            end
            if (k < 160 && (k % 16) < 8 && (k / 16) < 6) begin
                exp_addr = (k / 16) * 8 + (k % 16);
                if (int'(raddr_b) != exp_addr) bad++;
            end
            if (int'(raddr_b) > mx) mx = int'(raddr_b);
            if (k == 159) chk("b_addr_last", raddr_b, 19'd47);
            if (k == 160) chk("b_addr_wrap", raddr_b, 19'd0);
        end
        chk("b_addr_mismatches", bad, 0);
        chk("b_addr_max", mx, 47);
        chk("b_blank_low_per_frame", lo_bn, 112);
        chk("b_hsync_low_per_frame", lo_hs, 30);
        chk("b_vsync_low_per_frame", lo_vs, 32);
        chk("b_frame_start_count", n_fs, 1);
        goto(162);
        chk("b_frame_start_period", fs_b, 1'b1);

        // ---------------- instance B: reset at (5,3) of frame 2 ----------------
        goto(213);
        chk("b_addr_at_5_3", raddr_b, 19'd29);
        rst_b = 1'b1;
        goto(214);
        chk("b_midreset_outputs", {raddr_b, hs_b, vs_b, bn_b, fs_b, r_b, g_b, b_b},
            {19'd0, 4'b1100, 24'h0});
        release_b();
        first_hs = -1; first_vs = -1; n_fs = 0;
        for (int k = 0; k < 116; k++) begin
            goto(k);
            if (k < 2)
                chk($sformatf("b_post_reset_idle@%0d", k),
                    {hs_b, vs_b, bn_b, fs_b, r_b, g_b, b_b}, {4'b1100, 24'h0});
            if (k == 2)
                chk("b_post_reset_frame_start", {fs_b, bn_b}, 2'b11);
            if (fs_b) n_fs++;
            if (!hs_b && first_hs < 0) first_hs = k;
            if (!vs_b && first_vs < 0) first_vs = k;
        end
        chk("b_post_reset_fs_count", n_fs, 1);
        chk("b_post_reset_first_hsync", first_hs, 12);
        chk("b_post_reset_first_vsync", first_vs, 114);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_framebuffer_reader.md
Name: vga_framebuffer_reader

Overview:
- Scan-out side of the 640x480 3-bit pixel framebuffer. The character/index writers fill this framebuffer through its write port.
- Generates VGA timing and reads the framebuffer read port in row-major order using the same addressing as the writers: addr = y*640 + x.
- Drives sync, blank and 8-bit RGB to the DAC.
- Runs on the pixel clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
RD_LATENCY, 2, framebuffer read latency in clocks (1..4)

Ports:
clock  in  1  pixel clock
reset  in  1  synchronous, active-high reset
mem_raddr  out  19  framebuffer read address
mem_rdata  in  3  framebuffer read data, valid RD_LATENCY clocks after its address
vga_hsync  out  1  horizontal sync, active low
vga_vsync  out  1  vertical sync, active low
vga_blank_n  out  1  high during visible pixels
vga_r  out  8  red
vga_g  out  8  green
vga_b  out  8  blue
frame_start  out  1  one-clock pulse aligned with output of pixel (0,0)

Behaviour:
- Counters:
  - h_count runs 0..H_TOTAL-1, with H_TOTAL = sum of the H_* parameters (800 at defaults).
  - v_count runs 0..V_TOTAL-1, with V_TOTAL = 525 at defaults.
  - h_count wraps to 0 after H_TOTAL-1. v_count increments only on that wrap, and wraps to 0 after V_TOTAL-1.
- Raw timing, computed on the counters:
  - active = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
  - hsync_raw low for H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync_raw low for V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC (490..491). It is a function of v_count only, for whole lines.
- Address generation: incremental linear counter, no multiplier.
  - mem_raddr is the address for the current counter position when active.
  - It increments by 1 after each active clock.
  - It holds its value through blanking.
  - It returns to 0 on the clock where h_count = H_TOTAL-1 and v_count = V_TOTAL-1.
  - Maximum value is 307199. It never reaches 307200.
- Alignment pipeline:
  - active, hsync_raw, vsync_raw and the (0,0) flag are delayed through a RD_LATENCY-deep shift register. They then drive vga_blank_n, vga_hsync, vga_vsync and frame_start.
  - Result: every output for position (x,y) appears exactly RD_LATENCY clocks after the clock in which the counters equal (x,y).
  - mem_rdata is sampled in that same output cycle; there is no extra register beyond the shift-register depth.
- Colour mapping:
  - mem_rdata bit2 maps to R, bit1 to G, bit0 to B. Each set bit outputs 8'hFF; each clear bit outputs 8'h00.
  - When delayed active = 0, all RGB outputs are 8'h00 regardless of mem_rdata.
- Reset (synchronous, may occur at any point, including mid-line or mid-frame):
  - Clears h_count, v_count and mem_raddr to 0.
  - Clears the whole delay pipeline to the idle state: blank_n=0, hsync=1, vsync=1, frame_start=0.
  - Output values during reset and through the first RD_LATENCY clocks after release: vga_hsync=1, vga_vsync=1, vga_blank_n=0, vga_r=vga_g=vga_b=8'h00, frame_start=0, mem_raddr=0.
  - Counters start at (0,0) in the first clock with reset low. frame_start pulses RD_LATENCY clocks later.
- There is no backpressure and no stall: mem_rdata is trusted every cycle, and the memory must meet RD_LATENCY.
- Frame period is H_TOTAL*V_TOTAL clocks (420000 at defaults). frame_start is high exactly once per frame.

Test Plan:
- Reset, then release; memory model returns mem_rdata = addr[2:0] after 2 clocks. Required response: all outputs hold their reset values for 2 clocks, then frame_start=1, blank_n=1 and RGB=000000 for pixel 0; the next clock gives addr 1 → B=FF, R=G=00.
- Line 0 addressing: mem_raddr reads 639 at h=639, holds 639 for h=640..799, and reads 640 at h=0 of line 1. blank_n is low for exactly 160 clocks per line.
- Hsync timing: vga_hsync is low for exactly 96 clocks, starting 656+2 clocks after h=0. The next falling edge is 800 clocks later.
- Vsync and wrap: vga_vsync is low for exactly 1600 clocks (lines 490–491). The last visible address is 307199; the address returns to 0 at the frame boundary. Consecutive frame_start pulses are 420000 clocks apart.
- Blanking override: memory model forced to 3'b111 permanently. Required response: RGB = 00 whenever blank_n = 0, and FF/FF/FF whenever blank_n = 1.
- Reset mid-frame at h=300, v=200: the next clock shows mem_raddr=0 with pipeline outputs idle. frame_start fires 2 clocks after release, and no spurious hsync/vsync pulse appears.
